// File: rtl/fetch_stepper_if.sv
// Handshake/control bundle between the step sequencer and the datapath.
// master = sequencer side (drives step ring and fetch strobes).
// slave  = datapath/execute side (drives run and halt request).
interface fetch_stepper_if #(
  parameter int NUM_STEPS = 7,
  parameter int CNT_W     = 8
);
  logic                 run;
  logic                 halt_req;
  logic [NUM_STEPS-1:0] step;
  logic                 bus1;
  logic                 iar_e;
  logic                 iar_s;
  logic                 mar_s;
  logic                 ram_e;
  logic                 ir_s;
  logic                 acc_s;
  logic                 acc_e;
  logic                 fetch;
  logic                 instr_done;
  logic                 halted;
  logic [CNT_W-1:0]     instr_count;

  modport master (
    input  run, halt_req,
    output step, bus1, iar_e, iar_s, mar_s, ram_e, ir_s, acc_s, acc_e,
           fetch, instr_done, halted, instr_count
  );

  modport slave (
    output run, halt_req,
    input  step, bus1, iar_e, iar_s, mar_s, ram_e, ir_s, acc_s, acc_e,
           fetch, instr_done, halted, instr_count
  );
endinterface

// File: rtl/fetch_stepper.sv
// One-hot step ring plus fetch-phase strobes (steps 1-3) for the 7-step CPU.
// Latency: step advances one position per clock; strobes are combinational from the registered step.
// Backpressure: run=0 freezes the ring and zeroes all strobes; halt_req stops at the instruction boundary.
module fetch_stepper #(
  parameter int NUM_STEPS = 7,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  fetch_stepper_if.master ctl
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [NUM_STEPS-1:0] STEP1   = {{(NUM_STEPS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state;
  logic [NUM_STEPS-1:0] step_q;
  logic                 halt_pending;
  logic [CNT_W-1:0]     count_q;

  logic step_ok;
  logic active;
  logic last;

  // A corrupted ring is not trusted to drive the bus; it is also the trigger for recovery.
  assign step_ok = (step_q != '0) && ((step_q & (step_q - STEP1)) == '0);
  assign active  = (state == RUN) && ctl.run && step_ok;
  assign last    = step_q[NUM_STEPS-1];

  // Sequencer: state, step ring, sticky halt request and completed-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      step_q       <= '0;
      halt_pending <= 1'b0;
      count_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          step_q       <= '0;
          halt_pending <= 1'b0;
          if (ctl.run) begin
            state  <= RUN;
            step_q <= STEP1;
          end
        end
        RUN: begin
          if (!step_ok) begin
            // Illegal ring value: restart the instruction at step 1.
            step_q       <= STEP1;
            halt_pending <= halt_pending | ctl.halt_req;
          end else if (!ctl.run) begin
            // Paused: hold the step, but still remember a halt request.
            halt_pending <= halt_pending | ctl.halt_req;
          end else if (last) begin
            count_q <= count_q + CNT_ONE;
            if (halt_pending || ctl.halt_req) begin
              state        <= HALTED;
              step_q       <= '0;
              halt_pending <= 1'b0;
            end else begin
              step_q <= STEP1;
            end
          end else begin
            step_q       <= {step_q[NUM_STEPS-2:0], step_q[NUM_STEPS-1]};
            halt_pending <= halt_pending | ctl.halt_req;
          end
        end
        HALTED: begin
          step_q       <= '0;
          halt_pending <= 1'b0;
          // Leaving HALTED needs run to drop first, so a held run cannot restart it.
          if (!ctl.run) begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          step_q       <= '0;
          halt_pending <= 1'b0;
        end
      endcase
    end
  end

  // Fetch-phase decode: steps 1-3 own the bus, later steps belong to the execute decoder.
  always_comb begin
    ctl.bus1       = active & step_q[0];
    ctl.iar_e      = active & step_q[0];
    ctl.mar_s      = active & step_q[0];
    ctl.acc_s      = active & step_q[0];
    ctl.ram_e      = active & step_q[1];
    ctl.ir_s       = active & step_q[1];
    ctl.acc_e      = active & step_q[2];
    ctl.iar_s      = active & step_q[2];
    ctl.fetch      = active & (step_q[0] | step_q[1] | step_q[2]);
    ctl.instr_done = active & last;
  end

  assign ctl.step        = step_q;
  assign ctl.halted      = (state == HALTED);
  assign ctl.instr_count = count_q;

endmodule

// File: tb/tb_fetch_stepper.sv
// Directed bench for fetch_stepper: reset, stepping, pause, halt, async reset, counter wrap.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Every expected value is written out by hand or derived from the step index.
module tb_fetch_stepper;

  localparam int NS = 7;
  localparam int CW = 8;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  fetch_stepper_if #(.NUM_STEPS(NS), .CNT_W(CW)) bus ();

  fetch_stepper #(.NUM_STEPS(NS), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus.master)
  );

  // Strobe vector order: bus1 iar_e mar_s acc_s ram_e ir_s acc_e iar_s
  logic [7:0] strb;
  assign strb = {bus.bus1, bus.iar_e, bus.mar_s, bus.acc_s,
                 bus.ram_e, bus.ir_s, bus.acc_e, bus.iar_s};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_strb(input int s);
    case (s)
      0:       return 8'b1111_0000;
      1:       return 8'b0000_1100;
      2:       return 8'b0000_0011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    reset        = 1'b0;
    bus.run      = 1'b0;
    bus.halt_req = 1'b0;

    // ---- reset, then idle with run=0 ----
    #12;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_step",   32'(bus.step), 32'h0);
    chk("idle_strb",   32'(strb), 32'h0);
    chk("idle_fetch",  32'(bus.fetch), 32'h0);
    chk("idle_halted", 32'(bus.halted), 32'h0);
    chk("idle_count",  32'(bus.instr_count), 32'h0);

    // ---- free run for 15 clocks ----
    bus.run = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      int s;
      tick();
      s = (i - 1) % NS;
      chk("run_step",  32'(bus.step), 32'(1 << s));
      chk("run_strb",  32'(strb), 32'(exp_strb(s)));
      chk("run_fetch", 32'(bus.fetch), 32'(s < 3));
      chk("run_done",  32'(bus.instr_done), 32'(s == NS - 1));
      chk("run_count", 32'(bus.instr_count), 32'((i - 1) / NS));
      chk("run_bus_excl", 32'(int'(bus.iar_e) + int'(bus.ram_e) + int'(bus.acc_e) <= 1), 32'h1);
    end
    chk("run_count15", 32'(bus.instr_count), 32'd2);

    // ---- pause during step 4 ----
    for (int i = 0; i < 3; i++) tick();
    chk("pre_pause_step", 32'(bus.step), 32'h08);
    bus.run = 1'b0;
    #1;
    chk("pause_fetch", 32'(bus.fetch), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_step", 32'(bus.step), 32'h08);
      chk("pause_strb", 32'(strb), 32'h0);
      chk("pause_done", 32'(bus.instr_done), 32'h0);
    end
    bus.run = 1'b1;
    tick();
    chk("resume_step5", 32'(bus.step), 32'h10);
    tick();
    chk("resume_step6", 32'(bus.step), 32'h20);
    chk("resume_done6", 32'(bus.instr_done), 32'h0);
    tick();
    chk("resume_step7", 32'(bus.step), 32'h40);
    chk("resume_done7", 32'(bus.instr_done), 32'h1);
    tick();
    chk("resume_wrap",  32'(bus.step), 32'h01);
    chk("resume_count", 32'(bus.instr_count), 32'd3);

    // ---- halt request pulsed in step 2 ----
    tick();
    chk("halt_s2", 32'(bus.step), 32'h02);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    chk("halt_s3",     32'(bus.step), 32'h04);
    chk("halt_s3_strb", 32'(strb), 32'h03);
    for (int i = 0; i < 4; i++) tick();
    chk("halt_s7",      32'(bus.step), 32'h40);
    chk("halt_s7_done", 32'(bus.instr_done), 32'h1);
    chk("halt_s7_hlt",  32'(bus.halted), 32'h0);
    tick();
    chk("halted_flag",  32'(bus.halted), 32'h1);
    chk("halted_step",  32'(bus.step), 32'h0);
    chk("halted_strb",  32'(strb), 32'h0);
    chk("halted_count", 32'(bus.instr_count), 32'd4);
    tick();
    chk("halted_hold", 32'(bus.halted), 32'h1);
    chk("halted_hold_step", 32'(bus.step), 32'h0);
    bus.run = 1'b0;
    tick();
    chk("idle_again", 32'(bus.halted), 32'h0);
    chk("idle_again_step", 32'(bus.step), 32'h0);
    bus.run = 1'b1;
    tick();
    chk("restart_step", 32'(bus.step), 32'h01);
    chk("restart_strb", 32'(strb), 32'hF0);

    // ---- asynchronous reset in step 3 ----
    tick();
    tick();
    chk("ar_pre_step", 32'(bus.step), 32'h04);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_step",  32'(bus.step), 32'h0);
    chk("ar_strb",  32'(strb), 32'h0);
    chk("ar_count", 32'(bus.instr_count), 32'h0);
    chk("ar_fetch", 32'(bus.fetch), 32'h0);
    bus.run = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("ar_idle_step", 32'(bus.step), 32'h0);

    // ---- instruction counter wrap ----
    bus.run = 1'b1;
    tick();
    chk("wrap_start", 32'(bus.step), 32'h01);
    for (int i = 0; i < 255 * NS; i++) tick();
    chk("wrap_255",      32'(bus.instr_count), 32'd255);
    chk("wrap_255_step", 32'(bus.step), 32'h01);
    for (int i = 0; i < NS - 1; i++) tick();
    chk("wrap_last_step", 32'(bus.step), 32'h40);
    chk("wrap_last_done", 32'(bus.instr_done), 32'h1);
    tick();
    chk("wrap_zero",      32'(bus.instr_count), 32'd0);
    chk("wrap_zero_step", 32'(bus.step), 32'h01);
    tick();
    chk("wrap_next_step", 32'(bus.step), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
